ddram_byte_arbiter: RTL and testbench
=====================================

Name: ddram_byte_arbiter

Overview:
- Shares the single byte-wide DDRAM wrapper port between two kinds of requester: the HPS loader write path (ioctl download) and NCH wave playback read channels.
- Owns the rd/we strobe timing and the ready handshake, and generates the loader wait/back-pressure signal.
- Sits between hps_io/wave_sound and the ddram wrapper.
- Replaces the ad-hoc address mux and ioctl_wait logic in the top level.

Parameters:
- NCH, 4: number of playback read channels (1..8).
- AW, 28: byte address width.
- GUARD_CYC, 2: cycles after a strobe during which I_MEM_READY is ignored (range 1..7).
- TIMEOUT, 4096: watchdog limit in cycles; used only with the optional feature.

Ports:
- I_CLK  in  1  system clock.
- I_RSTn  in  1  asynchronous active-low reset.
- I_LD_WR  in  1  one-cycle loader write strobe.
- I_LD_ADDR  in  AW  loader byte address.
- I_LD_DATA  in  8  loader byte.
- I_LD_ACTIVE  in  1  download in progress; blocks channel grants.
- O_LD_WAIT  out  1  loader back-pressure (drives ioctl_wait).
- I_CH_REQ  in  NCH  per-channel read request, level.
- I_CH_ADDR  in  NCH*AW  packed channel addresses; channel k occupies bits [k*AW +: AW].
- O_CH_DATA  out  8  read data, shared by all channels.
- O_CH_VALID  out  NCH  one-hot, one-cycle data-valid.
- O_MEM_ADDR  out  AW  address to the ddram wrapper.
- O_MEM_DIN  out  8  write byte.
- O_MEM_WE  out  1  write strobe.
- O_MEM_RD  out  1  read strobe.
- I_MEM_DOUT  in  8  read byte from the wrapper.
- I_MEM_READY  in  1  wrapper idle / data ready.
- O_ERR  out  1  sticky timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer = 0, pending loader write cleared. Reset mid-transaction abandons the transaction; no valid pulse is emitted.
- FSM states: IDLE, ISSUE, GUARD, WAIT.
- Loader capture:
  - I_LD_WR latches address and data into a pending register in every state.
  - O_LD_WAIT goes to 1 on the next cycle.
  - A second I_LD_WR while O_LD_WAIT=1 is a protocol violation: ignored, pending data is unchanged.
- IDLE arbitration, evaluated only when I_MEM_READY=1:
  - A pending loader write always wins.
  - Otherwise, if I_LD_ACTIVE=0, the lowest-numbered requesting channel at or after the round-robin pointer (wrapping at NCH) is granted.
  - The granted address is registered onto O_MEM_ADDR, and O_MEM_DIN is registered for writes. Go to ISSUE.
  - If I_MEM_READY=0 or there is no request, stay in IDLE.
- ISSUE: assert O_MEM_WE or O_MEM_RD for exactly one cycle, then go to GUARD.
- GUARD: count GUARD_CYC cycles with I_MEM_READY ignored, then go to WAIT.
- WAIT: stay until I_MEM_READY=1. In that cycle:
  - Read: latch I_MEM_DOUT into O_CH_DATA and pulse O_CH_VALID[k] on the next cycle.
  - Write: clear pending and drop O_LD_WAIT on the next cycle.
  - Return to IDLE.
- Round-robin pointer: set to k+1 mod NCH when a channel read completes; loader writes do not move it.
- Latency: a read granted in IDLE at cycle t strobes at t+1. With ready returning at the first WAIT cycle, valid occurs at t+GUARD_CYC+3.
- Request withdrawal: if I_CH_REQ[k] is 0 at completion, the read still finishes on the memory side, but the data is discarded and no valid pulse is emitted.
- Channel requests stay level; a channel may keep REQ high to stream bytes and must update its address after each valid pulse.
- O_CH_DATA holds its value between valid pulses.
- O_MEM_ADDR and O_MEM_DIN stay stable from ISSUE through WAIT.
- Simultaneous I_LD_WR and channel requests in IDLE: the loader wins, even if the strobe arrives in the same cycle, because capture is combinationally bypassed into arbitration.
- I_LD_ACTIVE rising during a read: the read completes normally; no new grants are made.

Optional Feature:
- Macro: DDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in GUARD/WAIT.
  - Reaching TIMEOUT cycles forces the FSM to IDLE and sets O_ERR (sticky until reset).
  - A timed-out read emits no valid pulse.
  - A timed-out write clears pending and drops O_LD_WAIT.
- Not defined: no counter; O_ERR tied 0; WAIT may last indefinitely.

Test Plan:
- Single read: REQ[1]=1, addr 0x0000123, memory model returns 0xA5 with ready after 5 cycles. Expect exactly one O_MEM_RD pulse with addr 0x123, then O_CH_DATA=0xA5 with O_CH_VALID=4'b0010 for one cycle.
- Round-robin: REQ=4'b1111 held for 8 transactions. Expect grant order 0,1,2,3,0,1,2,3.
- Loader priority: I_LD_WR (addr 0x40, data 0x3C) in the same cycle as REQ[0]. Expect the write is issued first with O_LD_WAIT=1 until its ready, then the channel 0 read follows.
- Download lockout: I_LD_ACTIVE=1, REQ=4'b0001. Expect no O_MEM_RD. Three loader writes each complete with wait high, then low.
- Withdrawal and reset: drop REQ[2] during WAIT → no valid pulse. Assert I_RSTn=0 mid-WAIT → all outputs 0, FSM in IDLE.
- Timeout (with DDRAM_ARB_TIMEOUT_EN, TIMEOUT=16): ready held low. Expect return to IDLE after 16 cycles in GUARD/WAIT, O_ERR=1, no valid pulse.

Source files
------------

// File: rtl/ddram_byte_arbiter.sv
// ddram_byte_arbiter
// Shares the single byte-wide DDRAM wrapper port between the HPS loader write
// path and NCH round-robin playback read channels. Owns the rd/we strobe
// timing, the ready handshake and the loader back-pressure (O_LD_WAIT).
// Optional feature macro: DDRAM_ARB_TIMEOUT_EN (GUARD/WAIT watchdog that
// forces the FSM back to IDLE and raises a sticky O_ERR).
module ddram_byte_arbiter #(
    parameter int NCH       = 4,
    parameter int AW        = 28,
    parameter int GUARD_CYC = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic              I_LD_WR,
    input  logic [AW-1:0]     I_LD_ADDR,
    input  logic [7:0]        I_LD_DATA,
    input  logic              I_LD_ACTIVE,
    output logic              O_LD_WAIT,
    input  logic [NCH-1:0]    I_CH_REQ,
    input  logic [NCH*AW-1:0] I_CH_ADDR,
    output logic [7:0]        O_CH_DATA,
    output logic [NCH-1:0]    O_CH_VALID,
    output logic [AW-1:0]     O_MEM_ADDR,
    output logic [7:0]        O_MEM_DIN,
    output logic              O_MEM_WE,
    output logic              O_MEM_RD,
    input  logic [7:0]        I_MEM_DOUT,
    input  logic              I_MEM_READY,
    output logic              O_ERR
);

    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    // One counter serves both the guard window and the watchdog, so it is
    // sized for the larger of the two.
    localparam int CNTW = $clog2(TIMEOUT + 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   rr_q;
    logic [CW-1:0]   gnt_idx_q;
    logic            is_wr_q;
    logic            pend_q;
    logic [AW-1:0]   pend_addr_q;
    logic [7:0]      pend_data_q;
    logic [AW-1:0]   mem_addr_q;
    logic [7:0]      mem_din_q;
    logic            mem_we_q;
    logic            mem_rd_q;
    logic [7:0]      ch_data_q;
    logic [NCH-1:0]  ch_valid_q;
    logic [CNTW-1:0] cnt_q;

    // Unpacked view of the per-channel addresses.
    logic [AW-1:0]   ch_addr [NCH];

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch_addr
            assign ch_addr[gi] = I_CH_ADDR[gi*AW +: AW];
        end
    endgenerate

    // A loader strobe is accepted only when nothing is pending; while it is
    // being captured it is bypassed straight into arbitration so it wins
    // against channel requests arriving in the same cycle.
    logic            ld_cap;
    logic            ld_req;
    logic [AW-1:0]   ld_addr_eff;
    logic [7:0]      ld_data_eff;

    assign ld_cap      = I_LD_WR && !pend_q;
    assign ld_req      = pend_q || I_LD_WR;
    assign ld_addr_eff = pend_q ? pend_addr_q : I_LD_ADDR;
    assign ld_data_eff = pend_q ? pend_data_q : I_LD_DATA;

    // Round-robin pick: first requesting channel at or after rr_q, wrapping at NCH.
    logic            pick_found;
    logic [CW-1:0]   pick_idx;
    logic [CW:0]     pick_sum;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int i = 0; i < NCH; i++) begin
            pick_sum = {1'b0, rr_q} + (CW+1)'(i);
            if (pick_sum >= (CW+1)'(NCH)) begin
                pick_sum = pick_sum - (CW+1)'(NCH);
            end
            if (!pick_found && I_CH_REQ[pick_sum[CW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = pick_sum[CW-1:0];
            end
        end
    end

`ifdef DDRAM_ARB_TIMEOUT_EN
    logic err_q;
`endif

    // Arbiter FSM with loader capture; all outputs are registered here.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            gnt_idx_q   <= '0;
            is_wr_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            ch_data_q   <= '0;
            ch_valid_q  <= '0;
            cnt_q       <= '0;
`ifdef DDRAM_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            mem_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            ch_valid_q <= '0;

            if (ld_cap) begin
                pend_q      <= 1'b1;
                pend_addr_q <= I_LD_ADDR;
                pend_data_q <= I_LD_DATA;
            end

            case (state_q)
                S_IDLE: begin
                    if (I_MEM_READY) begin
                        if (ld_req) begin
                            is_wr_q    <= 1'b1;
                            mem_addr_q <= ld_addr_eff;
                            mem_din_q  <= ld_data_eff;
                            mem_we_q   <= 1'b1;
                            state_q    <= S_ISSUE;
                        end else if (!I_LD_ACTIVE && pick_found) begin
                            is_wr_q    <= 1'b0;
                            gnt_idx_q  <= pick_idx;
                            mem_addr_q <= ch_addr[pick_idx];
                            mem_rd_q   <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_GUARD;
                end

                S_GUARD: begin
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(GUARD_CYC - 1)) begin
                        state_q <= S_WAIT;
                    end
`ifdef DDRAM_ARB_TIMEOUT_EN
                    if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b1;
                        if (is_wr_q) begin
                            pend_q <= 1'b0;
                        end
                    end
`endif
                end

                S_WAIT: begin
                    if (I_MEM_READY) begin
                        state_q <= S_IDLE;
                        if (is_wr_q) begin
                            pend_q <= 1'b0;
                        end else begin
                            rr_q <= (gnt_idx_q == CW'(NCH - 1)) ? '0 : gnt_idx_q + CW'(1);
                            // A withdrawn request drops the byte silently.
                            if (I_CH_REQ[gnt_idx_q]) begin
                                ch_data_q              <= I_MEM_DOUT;
                                ch_valid_q[gnt_idx_q]  <= 1'b1;
                            end
                        end
                    end
`ifdef DDRAM_ARB_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + CNTW'(1);
                        if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            if (is_wr_q) begin
                                pend_q <= 1'b0;
                            end
                        end
                    end
`endif
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign O_LD_WAIT  = pend_q;
    assign O_CH_DATA  = ch_data_q;
    assign O_CH_VALID = ch_valid_q;
    assign O_MEM_ADDR = mem_addr_q;
    assign O_MEM_DIN  = mem_din_q;
    assign O_MEM_WE   = mem_we_q;
    assign O_MEM_RD   = mem_rd_q;
`ifdef DDRAM_ARB_TIMEOUT_EN
    assign O_ERR      = err_q;
`else
    assign O_ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_ddram_byte_arbiter.sv
// Testbench for ddram_byte_arbiter: directed steps, memory model, and a
// scoreboard of expected memory strobes and channel valid pulses.
module tb_ddram_byte_arbiter;

    localparam int NCH       = 4;
    localparam int AW        = 28;
    localparam int GUARD_CYC = 2;
    localparam int TIMEOUT   = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_wr;
    logic [AW-1:0]     ld_addr;
    logic [7:0]        ld_data;
    logic              ld_active;
    logic              ld_wait;
    logic [NCH-1:0]    ch_req;
    logic [AW-1:0]     ch_addr [NCH];
    logic [NCH*AW-1:0] ch_addr_bus;
    logic [7:0]        ch_data;
    logic [NCH-1:0]    ch_valid;
    logic [AW-1:0]     mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic              mem_rd;
    logic [7:0]        mem_dout;
    logic              mem_ready;
    logic              err;

    always #5 clk = ~clk;

    always_comb begin
        ch_addr_bus = '0;
        for (int k = 0; k < NCH; k++) ch_addr_bus[k*AW +: AW] = ch_addr[k];
    end

    ddram_byte_arbiter #(
        .NCH(NCH), .AW(AW), .GUARD_CYC(GUARD_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .I_CLK(clk), .I_RSTn(rst_n),
        .I_LD_WR(ld_wr), .I_LD_ADDR(ld_addr), .I_LD_DATA(ld_data),
        .I_LD_ACTIVE(ld_active), .O_LD_WAIT(ld_wait),
        .I_CH_REQ(ch_req), .I_CH_ADDR(ch_addr_bus),
        .O_CH_DATA(ch_data), .O_CH_VALID(ch_valid),
        .O_MEM_ADDR(mem_addr), .O_MEM_DIN(mem_din),
        .O_MEM_WE(mem_we), .O_MEM_RD(mem_rd),
        .I_MEM_DOUT(mem_dout), .I_MEM_READY(mem_ready),
        .O_ERR(err)
    );

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } mem_op_t;

    typedef struct {
        logic [NCH-1:0] vec;
        logic [7:0]     data;
    } val_t;

    mem_op_t exp_mem_q [$];
    val_t    exp_val_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int n_rd = 0, n_wr = 0, n_val = 0;
    int cyc = 0, strobe_cyc = 0, valid_cyc = 0;

    // Memory model: byte array, configurable ready latency, optional hang.
    logic [7:0] mem [256];
    logic [7:0] held_dout;
    int         mem_lat = 2;
    bit         mem_hang = 1'b0;
    int         busy;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem[8'h23] <= 8'hA5;
            mem_ready  <= 1'b1;
            mem_dout   <= 8'h00;
            held_dout  <= 8'h00;
            busy       <= 0;
        end else if (mem_rd || mem_we) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_din;
            if (mem_lat == 0) begin
                mem_dout <= mem[mem_addr[7:0]];
            end else begin
                held_dout <= mem[mem_addr[7:0]];
                mem_ready <= 1'b0;
                busy      <= mem_lat;
            end
        end else if (busy > 0) begin
            busy <= busy - 1;
            if (busy == 1 && !mem_hang) begin
                mem_ready <= 1'b1;
                mem_dout  <= held_dout;
            end
        end
    end

    function automatic logic [7:0] rd_exp(logic [7:0] a);
        return (a == 8'h23) ? 8'hA5 : (a ^ 8'h5A);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_mem(bit wr, logic [AW-1:0] a, logic [7:0] d);
        mem_op_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_mem_q.push_back(e);
    endtask

    task automatic push_val(logic [NCH-1:0] v, logic [7:0] d);
        val_t e;
        e.vec = v; e.data = d;
        exp_val_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valids(int target, string tag);
        int budget = 300;
        while (n_val < target && budget > 0) begin step(); budget--; end
        chk(tag, 32'(n_val >= target), 32'd1);
    endtask

    task automatic wait_strobes(int target, string tag);
        int budget = 300;
        while ((n_rd + n_wr) < target && budget > 0) begin step(); budget--; end
        chk(tag, 32'((n_rd + n_wr) >= target), 32'd1);
    endtask

    task automatic wait_ld_low(string tag);
        int budget = 300;
        while (ld_wait && budget > 0) begin step(); budget--; end
        chk(tag, 32'(ld_wait), 32'd0);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_addr"},  32'(mem_addr), 32'd0);
        chk({tag, "_din"},   32'(mem_din),  32'd0);
        chk({tag, "_we"},    32'(mem_we),   32'd0);
        chk({tag, "_rd"},    32'(mem_rd),   32'd0);
        chk({tag, "_wait"},  32'(ld_wait),  32'd0);
        chk({tag, "_valid"}, 32'(ch_valid), 32'd0);
        chk({tag, "_data"},  32'(ch_data),  32'd0);
        chk({tag, "_err"},   32'(err),      32'd0);
    endtask

    // Cycle counter used for latency measurements.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: compares every strobe and valid pulse with the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (mem_rd || mem_we) begin
                mem_op_t e;
                chk("strobe_both", 32'(mem_rd & mem_we), 32'd0);
                n_checks++;
                assert (exp_mem_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL unexpected_strobe observed rd=%0b we=%0b addr=0x%0h expected none",
                           mem_rd, mem_we, mem_addr);
                end
                if (exp_mem_q.size() != 0) begin
                    e = exp_mem_q.pop_front();
                    $display("[%0d] strobe %s addr=0x%0h din=0x%0h", cyc, mem_we ? "WR" : "RD", mem_addr, mem_din);
                    chk("strobe_kind", 32'(mem_we), 32'(e.wr));
                    chk("strobe_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.wr) chk("strobe_din", 32'(mem_din), 32'(e.data));
                end
                if (mem_rd) n_rd++;
                if (mem_we) n_wr++;
                strobe_cyc = cyc;
            end
            if (ch_valid != '0) begin
                val_t v;
                n_checks++;
                assert (exp_val_q.size() != 0) else begin
                    n_errors++;
                    $error("FAIL unexpected_valid observed vec=%b data=0x%0h expected none", ch_valid, ch_data);
                end
                if (exp_val_q.size() != 0) begin
                    v = exp_val_q.pop_front();
                    $display("[%0d] valid vec=%b data=0x%0h", cyc, ch_valid, ch_data);
                    chk("valid_vec",  32'(ch_valid), 32'(v.vec));
                    chk("valid_data", 32'(ch_data),  32'(v.data));
                end
                n_val++;
                valid_cyc = cyc;
            end
        end
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rbase, wbase, vbase, err_cyc;
        ld_wr = 0; ld_addr = '0; ld_data = '0; ld_active = 0; ch_req = '0;
        for (int k = 0; k < NCH; k++) ch_addr[k] = '0;
        rst_n = 0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1;
        step();

        // Single read from channel 1, ready after several cycles.
        mem_lat = 5; ch_addr[1] = 28'h0000123;
        push_mem(0, 28'h123, 8'h00); push_val(4'b0010, 8'hA5);
        rbase = n_rd; vbase = n_val;
        ch_req = 4'b0010;
        wait_valids(vbase + 1, "t1_valid_seen");
        ch_req = '0;
        repeat (10) step();
        chk("t1_rd_count", 32'(n_rd - rbase), 32'd1);
        chk("t1_data_hold", 32'(ch_data), 32'hA5);

        // Ready held high throughout: guard must still be honoured.
        mem_lat = 0; ch_addr[0] = 28'h0000005;
        push_mem(0, 28'h5, 8'h00); push_val(4'b0001, rd_exp(8'h05));
        vbase = n_val;
        ch_req = 4'b0001;
        wait_valids(vbase + 1, "t2_valid_seen");
        ch_req = '0;
        repeat (5) step();
        chk("t2_latency", 32'(valid_cyc - strobe_cyc), 32'(GUARD_CYC + 2));

        // Round robin from a fresh pointer.
        rst_n = 0; repeat (2) step(); rst_n = 1; step();
        mem_lat = 2;
        for (int k = 0; k < NCH; k++) ch_addr[k] = 28'h10 + 28'(k);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NCH; k++) begin
                push_mem(0, 28'h10 + 28'(k), 8'h00);
                push_val(NCH'(1) << k, rd_exp(8'h10 + 8'(k)));
            end
        vbase = n_val;
        ch_req = 4'b1111;
        wait_valids(vbase + 8, "t3_valids_seen");
        ch_req = '0;
        repeat (10) step();
        chk("t3_mem_q_empty", 32'(exp_mem_q.size()), 32'd0);

        // Loader write in the same cycle as a channel 0 request.
        mem_lat = 3; ch_addr[0] = 28'h50;
        push_mem(1, 28'h40, 8'h3C); push_mem(0, 28'h50, 8'h00);
        push_val(4'b0001, rd_exp(8'h50));
        rbase = n_rd; wbase = n_wr; vbase = n_val;
        ld_wr = 1; ld_addr = 28'h40; ld_data = 8'h3C; ch_req = 4'b0001;
        step();
        ld_wr = 0;
        chk("t4_wait_high", 32'(ld_wait), 32'd1);
        chk("t4_write_first", 32'(n_wr - wbase), 32'd1);
        wait_ld_low("t4_wait_low");
        chk("t4_no_rd_before_wr_done", 32'(n_rd - rbase), 32'd0);
        wait_valids(vbase + 1, "t4_valid_seen");
        ch_req = '0;
        repeat (5) step();

        // Second loader strobe while waiting is ignored.
        mem_lat = 8; ch_addr[3] = 28'h33;
        push_mem(0, 28'h33, 8'h00); push_val(4'b1000, rd_exp(8'h33));
        push_mem(1, 28'h70, 8'h11);
        wbase = n_wr; vbase = n_val;
        ch_req = 4'b1000;
        wait_strobes(n_rd + n_wr + 1, "t5_rd_strobe");
        step();
        ld_wr = 1; ld_addr = 28'h70; ld_data = 8'h11;
        step();
        ld_addr = 28'h71; ld_data = 8'h22;
        chk("t5_wait_high", 32'(ld_wait), 32'd1);
        step();
        ld_wr = 0;
        wait_valids(vbase + 1, "t5_valid_seen");
        ch_req = '0;
        wait_ld_low("t5_wait_low");
        repeat (10) step();
        chk("t5_wr_count", 32'(n_wr - wbase), 32'd1);

        // Download lockout: channel request blocked, loader writes still flow.
        ld_active = 1; ch_req = 4'b0001; ch_addr[0] = 28'h50;
        rbase = n_rd;
        for (int i = 0; i < 3; i++) begin
            push_mem(1, 28'h60 + 28'(i), 8'hC0 + 8'(i));
            ld_wr = 1; ld_addr = 28'h60 + 28'(i); ld_data = 8'hC0 + 8'(i);
            step();
            ld_wr = 0;
            chk("t6_wait_high", 32'(ld_wait), 32'd1);
            wait_ld_low("t6_wait_low");
        end
        repeat (10) step();
        chk("t6_no_rd", 32'(n_rd - rbase), 32'd0);
        ch_req = '0; ld_active = 0;
        step();

        // Withdrawal during WAIT: no valid, data output holds.
        mem_lat = 6; ch_addr[2] = 28'h22;
        push_mem(0, 28'h22, 8'h00);
        vbase = n_val;
        ch_req = 4'b0100;
        wait_strobes(n_rd + n_wr + 1, "t7_rd_strobe");
        repeat (4) step();
        ch_req = '0;
        repeat (15) step();
        chk("t7_no_valid", 32'(n_val - vbase), 32'd0);
        chk("t7_data_hold", 32'(ch_data), 32'(rd_exp(8'h33)));

        // Reset in the middle of WAIT.
        mem_lat = 10; ch_addr[1] = 28'h44;
        push_mem(0, 28'h44, 8'h00);
        ch_req = 4'b0010;
        wait_strobes(n_rd + n_wr + 1, "t8_rd_strobe");
        repeat (4) step();
        rst_n = 0;
        #1;
        check_all_zero("t8_reset");
        ch_req = '0;
        vbase = n_val;
        repeat (2) step();
        rst_n = 1;
        repeat (15) step();
        chk("t8_no_valid", 32'(n_val - vbase), 32'd0);
        mem_lat = 2; ch_addr[0] = 28'h06;
        push_mem(0, 28'h06, 8'h00); push_val(4'b0001, rd_exp(8'h06));
        ch_req = 4'b0001;
        wait_valids(vbase + 1, "t8_fresh_valid");
        ch_req = '0;
        repeat (5) step();

`ifdef DDRAM_ARB_TIMEOUT_EN
        // Watchdog: ready never returns.
        mem_hang = 1; mem_lat = 2; ch_addr[1] = 28'h07;
        push_mem(0, 28'h07, 8'h00);
        vbase = n_val;
        err_cyc = 0;
        ch_req = 4'b0010;
        wait_strobes(n_rd + n_wr + 1, "t9_rd_strobe");
        for (int i = 0; i < 100 && !err; i++) step();
        err_cyc = cyc;
        ch_req = '0;
        chk("t9_err", 32'(err), 32'd1);
        chk("t9_cycles", 32'(err_cyc - strobe_cyc), 32'(TIMEOUT + 1));
        repeat (5) step();
        chk("t9_no_valid", 32'(n_val - vbase), 32'd0);
        chk("t9_err_sticky", 32'(err), 32'd1);
        mem_hang = 0;
        rst_n = 0; repeat (2) step(); rst_n = 1; step();
`else
        err_cyc = 0;
        chk("err_tied", 32'(err), 32'(err_cyc));
`endif

        chk("end_mem_q_empty", 32'(exp_mem_q.size()), 32'd0);
        chk("end_val_q_empty", 32'(exp_val_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
